frame_compositor: RTL and testbench
===================================

FRAME_COMPOSITOR -- requirements
Module: frame_compositor

Interface
REQ-001 SHALL have parameter GROUND_ROW, default 402, giving the screen row drawn as the ground line.
REQ-002 SHALL have parameter SCORE_DIV, default 6, giving the number of frames per score point.
REQ-003 SHALL have port CLK  input  1  pixel clock; all state is updated on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame_tick  input  1  one-CLK pulse at end of each frame, synchronous to CLK.
REQ-006 SHALL have port video_on  input  1  high while row_addr/col_addr are in the visible area.
REQ-007 SHALL have port row_addr  input  9  current scan row.
REQ-008 SHALL have port col_addr  input  10  current scan column, reserved for layering; no function in this revision.
REQ-009 SHALL have port dino_px  input  1  dinosaur sprite pixel, aligned with row_addr/col_addr.
REQ-010 SHALL have port cactus_px  input  1  obstacle sprite pixel, aligned with row_addr/col_addr.
REQ-011 SHALL have port start_btn  input  1  start/restart button, level, already synchronous to CLK.
REQ-012 SHALL have port rgb  output  12  registered 4:4:4 pixel colour.
REQ-013 SHALL have port running  output  1  high in state RUN; drives the sprite stage's game-status input.
REQ-014 SHALL have port game_over  output  1  high in state OVER.
REQ-015 SHALL have port score  output  16  four packed BCD digits, thousands digit in [15:12].

Function
REQ-016 SHALL implement a 3-state FSM: IDLE, RUN, OVER.
REQ-017 SHALL detect a start edge as start_btn=1 with the previous-cycle registered start_btn=0.
REQ-018 SHALL, on a start edge, go IDLE->RUN and OVER->RUN; a start edge in RUN has no effect.
REQ-019 SHALL, in RUN, set a sticky hit flag in any cycle with video_on=1, dino_px=1 and cactus_px=1.
REQ-020 SHALL, on frame_tick in RUN with the hit flag (or a same-cycle hit) set, go RUN->OVER.
REQ-021 SHALL clear the hit flag on every frame_tick and on every entry to RUN.
REQ-022 SHALL keep a frame divider (0..SCORE_DIV-1) that advances only on frame_tick in RUN with no transition that cycle.
REQ-023 SHALL, when the divider wraps from SCORE_DIV-1 to 0, increment score by 1 in BCD with correct per-digit carry.
REQ-024 SHALL saturate score at 16'h9999.
REQ-025 SHALL clear the divider and score to 0 on every entry to RUN.
REQ-026 SHALL hold score unchanged in OVER so the final score remains visible.
REQ-027 SHALL give a start edge priority over frame_tick in the same cycle: transition taken, no divider or score update.
REQ-028 SHALL evaluate a hit and frame_tick in the same cycle as belonging to the ending frame.
REQ-029 SHALL register rgb with 1-CLK latency relative to its inputs, using the first matching priority below.
REQ-030 SHALL output rgb=12'h000 when video_on=0.
REQ-031 SHALL otherwise output rgb=12'h333 when dino_px=1.
REQ-032 SHALL otherwise output rgb=12'h070 when cactus_px=1.
REQ-033 SHALL otherwise output rgb=12'h555 when row_addr==GROUND_ROW.
REQ-034 SHALL otherwise output background rgb=12'hF88 in OVER and 12'hFFF in IDLE or RUN.
REQ-035 SHALL drive running and game_over directly from state registers, with no combinational path from inputs.

Reset
REQ-036 SHALL, while RESET=1, force: state=IDLE, rgb=0, running=0, game_over=0, score=0, divider=0, hit flag=0, start_btn history=1.
REQ-037 SHALL treat a button held through reset release as producing no start edge, because start_btn history resets to 1.
REQ-038 SHALL abort any operation when RESET asserts mid-frame or mid-RUN, with no residual hit or score.

Verification
REQ-039 SHALL verify: reset, then start pulse -> running=1 one cycle after the edge; score=0.
REQ-040 SHALL verify: RUN for 60 frame_ticks, SCORE_DIV=6, no overlap -> score=16'h0010.
REQ-041 SHALL verify: one pixel with dino_px=cactus_px=video_on=1 mid-frame -> game_over=1 after the next frame_tick; score frozen.
REQ-042 SHALL verify: overlap with video_on=0 -> no hit; frame_tick and start edge in the same cycle in OVER -> RUN, score=0.
REQ-043 SHALL verify: score preloaded to 0999 via 6 further ticks -> 1000; at 9999 -> stays 9999.
REQ-044 SHALL verify: pixel priority sweep (dino+cactus on GROUND_ROW) -> rgb 333 one cycle later; video_on=0 -> 000.

Source files
------------

// File: rtl/frame_compositor.sv
// rtl/frame_compositor.sv - game-state FSM, BCD score counter and registered pixel compositor
module frame_compositor #(
  parameter int GROUND_ROW = 402,
  parameter int SCORE_DIV  = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        frame_tick,
  input  logic        video_on,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        dino_px,
  input  logic        cactus_px,
  input  logic        start_btn,
  output logic [11:0] rgb,
  output logic        running,
  output logic        game_over,
  output logic [15:0] score
);

  localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCORE_DIV - 1);
  localparam logic [8:0] GROUND = 9'(GROUND_ROW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             start_prev_q, start_prev_d;
  logic             hit_q, hit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      score_q, score_d;
  logic [11:0]      rgb_q, rgb_d;

  logic start_edge;
  logic hit_now;

  // Column address is carried for future layering only.
  logic unused_col;
  assign unused_col = ^col_addr;

  // Increment four packed BCD digits with ripple carry, saturating at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign start_edge = start_btn & ~start_prev_q;
  assign hit_now    = video_on & dino_px & cactus_px;

  // Next-state logic for the game FSM, hit flag, frame divider and score.
  always_comb begin
    state_d      = state_q;
    start_prev_d = start_btn;
    hit_d        = hit_q;
    div_d        = div_q;
    score_d      = score_q;
    unique case (state_q)
      IDLE, OVER: begin
        // A start edge wins over a same-cycle frame_tick: fresh game, no counting.
        if (start_edge) begin
          state_d = RUN;
          hit_d   = 1'b0;
          div_d   = '0;
          score_d = '0;
        end
      end
      RUN: begin
        if (frame_tick) begin
          hit_d = 1'b0;
          // A collision on the tick cycle still belongs to the frame that is ending.
          if (hit_q || hit_now) begin
            state_d = OVER;
          end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            score_d = bcd_inc(score_q);
          end else begin
            div_d = div_q + 1'b1;
          end
        end else if (hit_now) begin
          hit_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel priority: blanking, dinosaur, obstacle, ground line, background.
  always_comb begin
    rgb_d = 12'hFFF;
    if (!video_on)                rgb_d = 12'h000;
    else if (dino_px)             rgb_d = 12'h333;
    else if (cactus_px)           rgb_d = 12'h070;
    else if (row_addr == GROUND)  rgb_d = 12'h555;
    else if (state_q == OVER)     rgb_d = 12'hF88;
  end

  // State registers; button history resets high so a held button is not an edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b1;
      hit_q        <= 1'b0;
      div_q        <= '0;
      score_q      <= '0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      hit_q        <= hit_d;
      div_q        <= div_d;
      score_q      <= score_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rgb       = rgb_q;
  assign score     = score_q;
  assign running   = (state_q == RUN);
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_frame_compositor.sv
// tb/tb_frame_compositor.sv - directed self-checking bench for frame_compositor
module tb_frame_compositor;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        frame_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [8:0]  row_addr = '0;
  logic [9:0]  col_addr = '0;
  logic        dino_px = 1'b0;
  logic        cactus_px = 1'b0;
  logic        start_btn = 1'b0;
  logic [11:0] rgb;
  logic        running;
  logic        game_over;
  logic [15:0] score;

  int errors = 0;
  int checks = 0;

  frame_compositor #(.GROUND_ROW(402), .SCORE_DIV(6)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .frame_tick (frame_tick),
    .video_on   (video_on),
    .row_addr   (row_addr),
    .col_addr   (col_addr),
    .dino_px    (dino_px),
    .cactus_px  (cactus_px),
    .start_btn  (start_btn),
    .rgb        (rgb),
    .running    (running),
    .game_over  (game_over),
    .score      (score)
  );

  always #5 CLK = ~CLK;

  // Compare one observed value with its expected value and log any mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Hold frame_tick high for n consecutive rising edges.
  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  // Drive one pixel's worth of inputs.
  task automatic pix(input logic v, input logic d, input logic c, input logic [8:0] r);
    video_on  = v;
    dino_px   = d;
    cactus_px = c;
    row_addr  = r;
  endtask

  initial begin
    repeat (3) step();
    check("reset_running", running, 0);
    check("reset_over", game_over, 0);
    check("reset_score", score, 0);
    check("reset_rgb", rgb, 0);
    RESET = 1'b0;
    step();

    start_btn = 1'b1;
    step();
    check("start_running", running, 1);
    check("start_score", score, 0);
    start_btn = 1'b0;
    step();

    ticks(60);
    check("score_60_ticks", score, 16'h0010);
    ticks(5934);
    check("score_0999", score, 16'h0999);
    ticks(5);
    check("score_0999_hold", score, 16'h0999);
    ticks(1);
    check("score_1000", score, 16'h1000);
    ticks(53994);
    check("score_9999", score, 16'h9999);
    ticks(12);
    check("score_saturate", score, 16'h9999);

    start_btn = 1'b1;
    step();
    check("start_in_run", running, 1);
    check("start_in_run_score", score, 16'h9999);
    start_btn = 1'b0;

    pix(1'b0, 1'b1, 1'b1, 9'd402);
    step();
    check("rgb_blank", rgb, 12'h000);
    pix(1'b0, 1'b0, 1'b0, 9'd0);
    ticks(1);
    check("no_hit_blank", running, 1);

    pix(1'b1, 1'b1, 1'b1, 9'd402);
    step();
    check("rgb_dino_prio", rgb, 12'h333);
    check("hit_waits_tick", running, 1);
    pix(1'b1, 1'b0, 1'b1, 9'd402);
    step();
    check("rgb_cactus", rgb, 12'h070);
    pix(1'b1, 1'b0, 1'b0, 9'd402);
    step();
    check("rgb_ground", rgb, 12'h555);
    pix(1'b1, 1'b0, 1'b0, 9'd100);
    step();
    check("rgb_bg_run", rgb, 12'hFFF);
    ticks(1);
    check("over_after_hit", game_over, 1);
    check("over_not_running", running, 0);
    check("over_score_frozen", score, 16'h9999);
    step();
    check("rgb_bg_over", rgb, 12'hF88);
    ticks(3);
    check("over_score_hold", score, 16'h9999);

    start_btn  = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    check("restart_running", running, 1);
    check("restart_score", score, 0);
    pix(1'b0, 1'b0, 1'b0, 9'd0);
    ticks(5);
    check("restart_div_clear", score, 0);
    ticks(1);
    check("restart_first_pt", score, 16'h0001);

    pix(1'b1, 1'b1, 1'b1, 9'd10);
    step();
    start_btn = 1'b1;
    #2 RESET = 1'b1;
    #1;
    check("async_reset_running", running, 0);
    check("async_reset_score", score, 0);
    check("async_reset_rgb", rgb, 0);
    pix(1'b1, 1'b0, 1'b0, 9'd10);
    step();
    RESET = 1'b0;
    step();
    step();
    check("held_btn_no_start", running, 0);
    check("rgb_bg_idle", rgb, 12'hFFF);
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    check("start_after_reset", running, 1);
    start_btn = 1'b0;
    ticks(1);
    check("no_residual_hit", running, 1);
    check("no_residual_over", game_over, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
